// File: rtl/systolic_pe_mac_if.sv
// Operand, control and drain-port bundle for one systolic MAC processing element.
// The master side drives operands and control; the slave side is the PE.
interface systolic_pe_mac_if #(
  parameter int unsigned DATA_W = 8
);
  logic              en;
  logic [DATA_W-1:0] a_in;
  logic              a_valid_in;
  logic [DATA_W-1:0] b_in;
  logic              b_valid_in;
  logic              clear;
  logic              drain_start;
  logic [DATA_W-1:0] a_out;
  logic              a_valid_out;
  logic [DATA_W-1:0] b_out;
  logic              b_valid_out;
  logic [7:0]        dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              ovf;
  logic              err;

  modport master (
    output en, a_in, a_valid_in, b_in, b_valid_in, clear, drain_start, dout_ready,
    input  a_out, a_valid_out, b_out, b_valid_out, dout, dout_valid, dout_last, ovf, err
  );

  modport slave (
    input  en, a_in, a_valid_in, b_in, b_valid_in, clear, drain_start, dout_ready,
    output a_out, a_valid_out, b_out, b_valid_out, dout, dout_valid, dout_last, ovf, err
  );
endinterface

// File: rtl/systolic_pe_mac.sv
// Signed saturating MAC processing element with west/east and north/south operand
// forwarding and a byte-serial valid/ready drain of the accumulator snapshot.
module systolic_pe_mac #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input logic              clk,
  input logic              rst_n,
  systolic_pe_mac_if.slave bus
);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned NB     = ((ACC_W + 7) / 8) * 8;
  localparam int unsigned NBYTES = NB / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_e;

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_ovf;
  logic                     r_err;
  logic [NB-1:0]            r_shreg;
  logic [CNT_W-1:0]         r_byte_cnt;
  logic [DATA_W-1:0]        r_a;
  logic [DATA_W-1:0]        r_b;
  logic                     r_a_v;
  logic                     r_b_v;

  logic                     w_mac;
  logic                     w_mismatch;
  logic                     w_snap;
  logic                     w_drain_err;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_sat_hi;
  logic                     w_sat_lo;
  logic                     w_dout_valid;
  logic [7:0]               w_dout;
  logic                     w_dout_last;
  logic signed [PROD_W-1:0] w_a_ext;
  logic signed [PROD_W-1:0] w_b_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W:0]    w_sum;
  logic signed [ACC_W-1:0]  w_acc_nxt;

  // Product and one-bit-wider sum; a clear or snapshot zeroes the addend base.
  always_comb begin
    w_mac       = bus.a_valid_in & bus.b_valid_in;
    w_mismatch  = bus.a_valid_in ^ bus.b_valid_in;
    w_snap      = bus.drain_start && (r_state == S_RUN);
    w_drain_err = bus.drain_start && (r_state == S_DRAIN);
    w_a_ext     = PROD_W'($signed(bus.a_in));
    w_b_ext     = PROD_W'($signed(bus.b_in));
    w_prod      = w_a_ext * w_b_ext;
    w_base      = (bus.clear || w_snap) ? '0 : r_acc;
    w_sum       = (ACC_W+1)'(w_base) + (ACC_W+1)'(w_prod);
    w_sat_hi    = !w_sum[ACC_W] &&  w_sum[ACC_W-1];
    w_sat_lo    =  w_sum[ACC_W] && !w_sum[ACC_W-1];
    if (w_sat_hi)      w_acc_nxt = ACC_MAX;
    else if (w_sat_lo) w_acc_nxt = ACC_MIN;
    else               w_acc_nxt = w_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else if (bus.en) begin
      if (w_mac)                    r_acc <= w_acc_nxt;
      else if (bus.clear || w_snap) r_acc <= '0;
      if (bus.clear)                           r_ovf <= 1'b0;
      else if (w_mac && (w_sat_hi || w_sat_lo)) r_ovf <= 1'b1;
      if (bus.clear)                        r_err <= 1'b0;
      else if (w_mismatch || w_drain_err)   r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_a_v <= 1'b0;
      r_b_v <= 1'b0;
    end else if (bus.en) begin
      if (bus.a_valid_in) r_a <= bus.a_in;
      if (bus.b_valid_in) r_b <= bus.b_in;
      r_a_v <= bus.a_valid_in;
      r_b_v <= bus.b_valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else if (bus.en) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dout_valid = 1'b0;
    w_dout       = '0;
    w_dout_last  = 1'b0;
    w_accept     = 1'b0;
    w_last       = (r_byte_cnt == CNT_W'(NBYTES - 1));
    case (r_state)
      S_RUN: begin
        if (bus.drain_start) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_dout_valid = bus.en;
        w_dout       = r_shreg[7:0];
        w_dout_last  = w_last;
        w_accept     = bus.en && bus.dout_ready;
        if (w_accept && w_last) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Snapshot is sign-extended to whole bytes; each accept shifts out the low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_byte_cnt <= '0;
    end else if (bus.en) begin
      if (w_snap) begin
        r_shreg    <= NB'(r_acc);
        r_byte_cnt <= '0;
      end else if (w_accept) begin
        r_shreg    <= r_shreg >> 8;
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.a_out       = r_a;
  assign bus.a_valid_out = r_a_v;
  assign bus.b_out       = r_b;
  assign bus.b_valid_out = r_b_v;
  assign bus.dout        = w_dout;
  assign bus.dout_valid  = w_dout_valid;
  assign bus.dout_last   = w_dout_last;
  assign bus.ovf         = r_ovf;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_systolic_pe_mac.sv
// Directed bench for systolic_pe_mac: accumulate, saturate, drain handshake,
// forwarding, error flags, async reset and enable freeze.
module tb_systolic_pe_mac;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  systolic_pe_mac_if #(.DATA_W(8)) bus ();

  systolic_pe_mac #(.DATA_W(8), .ACC_W(20)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mac(input logic [7:0] a, input logic [7:0] b);
    bus.a_in       = a;
    bus.b_in       = b;
    bus.a_valid_in = 1'b1;
    bus.b_valid_in = 1'b1;
    tick();
    bus.a_valid_in = 1'b0;
    bus.b_valid_in = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic drain3(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input bit with_mac,
                        input logic [7:0] ma, input logic [7:0] mb);
    logic [7:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    bus.drain_start = 1'b1;
    bus.dout_ready  = 1'b1;
    if (with_mac) begin
      bus.a_in = ma; bus.b_in = mb;
      bus.a_valid_in = 1'b1; bus.b_valid_in = 1'b1;
    end
    tick();
    bus.drain_start = 1'b0;
    bus.a_valid_in  = 1'b0;
    bus.b_valid_in  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_v%0d", tag, i), bus.dout_valid, 1'b1);
      chk($sformatf("%s_d%0d", tag, i), bus.dout, e[i]);
      chk($sformatf("%s_l%0d", tag, i), bus.dout_last, (i == 2));
      tick();
    end
    chk({tag, "_end"}, bus.dout_valid, 1'b0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    bus.en = 1'b1; bus.a_in = '0; bus.b_in = '0; bus.a_valid_in = 1'b0; bus.b_valid_in = 1'b0;
    bus.clear = 1'b0; bus.drain_start = 1'b0; bus.dout_ready = 1'b0;
    #12;
    chk("rst_dv",  bus.dout_valid, 1'b0);
    chk("rst_aout", bus.a_out, 8'h00);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    rst_n = 1'b1;
    tick();

    // T1: basic accumulate and forwarding
    mac(8'h03, 8'h04);
    chk("t1_aout", bus.a_out, 8'h03);
    chk("t1_avo",  bus.a_valid_out, 1'b1);
    chk("t1_bout", bus.b_out, 8'h04);
    mac(8'hFE, 8'h05);
    mac(8'h7F, 8'h7F);
    tick();
    chk("t1_avo0", bus.a_valid_out, 1'b0);
    chk("t1_ahold", bus.a_out, 8'h7F);
    drain3("t1", 8'h03, 8'h3F, 8'h00, 1'b0, 8'h00, 8'h00);

    // T2: positive saturation
    for (int i = 0; i < 31; i++) mac(8'h80, 8'h80);
    chk("t2_ovf0", bus.ovf, 1'b0);
    mac(8'h80, 8'h80);
    chk("t2_ovf1", bus.ovf, 1'b1);
    drain3("t2", 8'hFF, 8'hFF, 8'h07, 1'b0, 8'h00, 8'h00);
    pulse_clear();
    chk("t2_clr", bus.ovf, 1'b0);

    // negative saturation
    for (int i = 0; i < 32; i++) mac(8'h80, 8'h7F);
    chk("tn_ovf0", bus.ovf, 1'b0);
    mac(8'h80, 8'h7F);
    chk("tn_ovf1", bus.ovf, 1'b1);
    drain3("tn", 8'h00, 8'h00, 8'hF8, 1'b0, 8'h00, 8'h00);
    pulse_clear();

    // T3: negative drain, then a MAC in the drain_start cycle lands in the fresh acc
    mac(8'hFF, 8'h01);
    drain3("t3a", 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'h02, 8'h03);
    drain3("t3b", 8'h06, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);

    // T4: backpressure stall and ignored drain_start
    mac(8'd100, 8'd100);
    bus.drain_start = 1'b1; bus.dout_ready = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    chk("t4_d0", bus.dout, 8'h10);
    tick();
    chk("t4_d1", bus.dout, 8'h27);
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.drain_start = 1'b1;
      tick();
      bus.drain_start = 1'b0;
      chk($sformatf("t4_sv%0d", i), bus.dout_valid, 1'b1);
      chk($sformatf("t4_sd%0d", i), bus.dout, 8'h27);
    end
    chk("t4_err", bus.err, 1'b1);
    bus.dout_ready = 1'b1;
    tick();
    chk("t4_d2", bus.dout, 8'h00);
    chk("t4_l2", bus.dout_last, 1'b1);
    tick();
    chk("t4_end", bus.dout_valid, 1'b0);
    pulse_clear();
    chk("t4_clr", bus.err, 1'b0);

    // T5: lone A valid forwards, skips the MAC and flags err
    mac(8'h03, 8'h03);
    bus.a_in = 8'h55; bus.b_in = 8'h66; bus.a_valid_in = 1'b1;
    tick();
    bus.a_valid_in = 1'b0;
    chk("t5_aout", bus.a_out, 8'h55);
    chk("t5_avo",  bus.a_valid_out, 1'b1);
    chk("t5_bvo",  bus.b_valid_out, 1'b0);
    chk("t5_bout", bus.b_out, 8'h03);
    chk("t5_err",  bus.err, 1'b1);
    drain3("t5", 8'h09, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    pulse_clear();
    chk("t5_clr", bus.err, 1'b0);

    // T6: async reset mid-drain
    mac(8'd50, 8'd60);
    bus.drain_start = 1'b1; bus.dout_ready = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    chk("t6_d0", bus.dout, 8'hB8);
    tick();
    chk("t6_d1", bus.dout, 8'h0B);
    rst_n = 1'b0;
    #1;
    chk("t6_rdv", bus.dout_valid, 1'b0);
    chk("t6_rd",  bus.dout, 8'h00);
    chk("t6_raout", bus.a_out, 8'h00);
    rst_n = 1'b1;
    tick();

    // enable freeze: forwarding and state hold, no MAC, no drain start
    mac(8'd7, 8'd8);
    bus.en = 1'b0;
    bus.a_in = 8'd9; bus.b_in = 8'd9; bus.a_valid_in = 1'b1; bus.b_valid_in = 1'b1;
    bus.drain_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_fa%0d", i), bus.a_out, 8'd7);
      chk($sformatf("t6_fv%0d", i), bus.a_valid_out, 1'b1);
      chk($sformatf("t6_fdv%0d", i), bus.dout_valid, 1'b0);
    end
    bus.en = 1'b1; bus.a_valid_in = 1'b0; bus.b_valid_in = 1'b0; bus.drain_start = 1'b0;
    tick();
    chk("t6_avo0", bus.a_valid_out, 1'b0);
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    chk("t6_e0", bus.dout, 8'h38);
    bus.en = 1'b0;
    #1;
    chk("t6_endv", bus.dout_valid, 1'b0);
    tick();
    bus.en = 1'b1;
    #1;
    chk("t6_env", bus.dout_valid, 1'b1);
    chk("t6_ehold", bus.dout, 8'h38);
    tick();
    chk("t6_e1", bus.dout, 8'h00);
    tick();
    chk("t6_e2l", bus.dout_last, 1'b1);
    tick();
    chk("t6_eend", bus.dout_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
